// File: rtl/mul_unit.sv
// Iterative 64x64 radix-2 shift-and-add multiplier (MUL / UMULH / SMULH).
// Fixed latency: one accept edge, 64 iteration edges, one sign-fix/select edge.
module mul_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULH = 2'b01;
    localparam logic [1:0] OP_SMULH = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // |most-negative| wraps back to itself, which is the correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        if (v[WIDTH-1]) begin
            u = ~u + WIDTH'(1);
        end
        return u;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_negate(input logic [2*WIDTH-1:0] v,
                                                       input logic             neg);
        logic [2*WIDTH-1:0] r;
        r = v;
        if (neg) begin
            r = ~v + (2*WIDTH)'(1);
        end
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   ma_q, ma_d;
    logic [WIDTH-1:0]     mb_q, mb_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic                 hi_q, hi_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [2*WIDTH-1:0]   product;
    logic                 is_smulh;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        result_d = result_q;
        done_d   = 1'b0;
        product  = '0;
        is_smulh = (op == OP_SMULH);

        case (state_q)
            IDLE: begin
                if (start) begin
                    ma_d    = {{WIDTH{1'b0}}, (is_smulh ? magnitude(a) : a)};
                    mb_d    = is_smulh ? magnitude(b) : b;
                    neg_d   = is_smulh & (a[WIDTH-1] ^ b[WIDTH-1]);
                    hi_d    = (op == OP_UMULH) || (op == OP_SMULH);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // ma is pre-shifted each step, so ma_q == multiplicand << i here.
                if (mb_q[0]) begin
                    acc_d = acc_q + ma_q;
                end
                ma_d  = ma_q << 1;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                product  = cond_negate(acc_q, neg_q);
                result_d = hi_q ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == FIX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Operand shadows are only consumed after an accept, so they need no reset.
    always_ff @(posedge clk) begin
        ma_q  <= ma_d;
        mb_q  <= mb_d;
        neg_q <= neg_d;
        hi_q  <= hi_d;
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Scoreboard bench for mul_unit: driver pushes expected results, monitor pops on done.
module tb_mul_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op_i;
    logic [63:0] a_i;
    logic [63:0] b_i;
    logic        busy;
    logic        done;
    logic [63:0] result;

    mul_unit #(.WIDTH(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op_i),
        .a      (a_i),
        .b      (b_i),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    typedef struct {
        logic [63:0] val;
        int          when;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e_pop;
    int          cyc = 0;
    int          acc_cyc = -1000;
    logic [63:0] res_model = 64'd0;
    bit          mon_en = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] x,
                                            input logic [63:0] y);
        logic signed [127:0] sx, sy, sp;
        logic [127:0]        up;
        case (o)
            2'b01: begin
                up = {64'd0, x} * {64'd0, y};
                return up[127:64];
            end
            2'b10: begin
                sx = $signed({{64{x[63]}}, x});
                sy = $signed({{64{y[63]}}, y});
                sp = sx * sy;
                return sp[127:64];
            end
            default: return x * y;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Call at a negedge; acceptance happens on the next rising edge.
    task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                         input bit keep);
        exp_t e;
        op_i    = o;
        a_i     = x;
        b_i     = y;
        start   = 1'b1;
        acc_cyc = cyc + 1;
        e.val   = ref_mul(o, x, y);
        e.when  = cyc + 1 + 65;
        sb_q.push_back(e);
        @(negedge clk);
        if (!keep) start = 1'b0;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            chk("busy", 64'(busy), 64'((cyc >= acc_cyc) && (cyc <= acc_cyc + 64)));
            chk("done", 64'(done), 64'(cyc == acc_cyc + 65));
            chk("busy_done_excl", 64'(busy & done), 64'd0);
            if (done) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e_pop = sb_q.pop_front();
                    res_model = e_pop.val;
                    chk("done_cycle", 64'(cyc), 64'(e_pop.when));
                end
            end
            chk("result", result, res_model);
        end
    end

    initial begin
        logic [63:0] specials [0:5];
        logic [63:0] x, y;
        logic [1:0]  o;
        int          r;
        specials[0] = 64'd0;
        specials[1] = 64'd1;
        specials[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        specials[3] = 64'h8000_0000_0000_0000;
        specials[4] = 64'h7FFF_FFFF_FFFF_FFFF;
        specials[5] = 64'hFFFF_FFFF_FFFF_FFFD;

        reset = 1'b1;
        start = 1'b0;
        op_i  = 2'b00;
        a_i   = 64'd0;
        b_i   = 64'd0;
        wait_neg(3);
        reset  = 1'b0;
        mon_en = 1'b1;
        wait_neg(2);

        issue(2'b00, 64'd3, 64'd5, 1'b0);
        wait_neg(67);
        issue(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wait_neg(66);
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        wait_neg(66);
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        wait_neg(66);
        issue(2'b10, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
        wait_neg(66);
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0);
        wait_neg(66);
        issue(2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b0);
        wait_neg(66);
        issue(2'b11, 64'd12, 64'd11, 1'b0);
        wait_neg(66);

        // Start and operand changes while busy must be ignored.
        issue(2'b00, 64'd7, 64'd9, 1'b0);
        wait_neg(3);
        start = 1'b1;
        a_i   = 64'd2;
        b_i   = 64'd2;
        wait_neg(1);
        start = 1'b0;
        wait_neg(5);
        a_i   = 64'hDEAD_BEEF_0000_1234;
        b_i   = 64'h1234;
        wait_neg(56);
        wait_neg(6);

        // Reset 30 cycles into an UMULH abandons it.
        issue(2'b01, 64'hFFFF_0000_FFFF_0000, 64'h1234_5678_9ABC_DEF0, 1'b0);
        wait_neg(29);
        reset     = 1'b1;
        acc_cyc   = -1000;
        sb_q.delete();
        res_model = 64'd0;
        wait_neg(1);
        reset = 1'b0;
        wait_neg(2);
        issue(2'b00, 64'd4, 64'd4, 1'b0);
        wait_neg(66);

        // Start held high; operands switched on the done cycle.
        issue(2'b00, 64'd2, 64'd3, 1'b1);
        wait_neg(65);
        issue(2'b00, 64'd6, 64'd7, 1'b0);
        wait_neg(66);

        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)]
                                            : {$urandom, $urandom};
            y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)]
                                            : {$urandom, $urandom};
            issue(o, x, y, 1'b0);
            r = $urandom_range(1, 50);
            wait_neg(r);
            start = 1'b1;
            op_i  = 2'($urandom_range(0, 3));
            a_i   = {$urandom, $urandom};
            b_i   = {$urandom, $urandom};
            wait_neg(1);
            start = 1'b0;
            wait_neg(64 - r);
            wait_neg($urandom_range(0, 3));
        end

        wait_neg(70);
        chk("queue_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
